// File: rtl/pht_predictor.sv
// -----------------------------------------------------------------------------
// pht_predictor
//   Gshare pattern history table, lookup side.
//   - 2^INDEX_W two-bit saturating counters, reset to strongly taken (2'b11).
//   - Prediction answered one cycle after request, index = pc slice XOR ghr.
//   - Resolved-branch updates step the addressed counter and shift the
//     non-speculative global history register.
//   Optional build macro: PHT_BYPASS_EN
//     When defined, a prediction that hits the index being updated at the
//     same edge returns the post-update counter value instead of the
//     pre-update one. Table contents after the edge are the same in both
//     builds.
// -----------------------------------------------------------------------------
module pht_predictor #(
  parameter int INDEX_W = 6,
  parameter int PC_LSB  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               pred_out_valid,
  output logic               pred_taken,
  output logic [1:0]         pred_ctr,
  output logic [INDEX_W-1:0] pred_idx,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               upd_taken,
  output logic [INDEX_W-1:0] ghr_out
);

  localparam int DEPTH = 1 << INDEX_W;

  // Two-bit saturating counter step: taken counts up, not taken counts down,
  // both clamp at the ends instead of wrapping.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case (ctr)
      2'b11:   nxt = taken ? 2'b11 : 2'b10;
      2'b10:   nxt = taken ? 2'b11 : 2'b01;
      2'b01:   nxt = taken ? 2'b10 : 2'b00;
      2'b00:   nxt = taken ? 2'b01 : 2'b00;
      default: nxt = 2'b11;
    endcase
    return nxt;
  endfunction

  // Storage and state
  logic [1:0]         table_r [DEPTH];
  logic [INDEX_W-1:0] ghr_r;
  logic               pred_out_valid_r;
  logic               pred_taken_r;
  logic [1:0]         pred_ctr_r;
  logic [INDEX_W-1:0] pred_idx_r;

  // Combinational datapath
  logic [INDEX_W-1:0] lookup_idx_s;
  logic [1:0]         upd_next_s;
  logic [1:0]         read_ctr_s;
  logic               unused_pc_s;

  // PC bits outside the index window do not take part in the hash.
  assign unused_pc_s = ^{pred_pc[31:PC_LSB+INDEX_W], pred_pc[PC_LSB-1:0]};

  // Gshare hash uses the GHR as currently registered, i.e. before any
  // shift caused by an update at the same edge.
  assign lookup_idx_s = pred_pc[PC_LSB +: INDEX_W] ^ ghr_r;

  // Next value of the counter being updated this cycle.
  assign upd_next_s = ctr_step(table_r[upd_idx], upd_taken);

  // Select the counter value returned by a lookup, with optional forwarding
  // of a same-edge update to the same entry.
  always_comb begin
    read_ctr_s = table_r[lookup_idx_s];
`ifdef PHT_BYPASS_EN
    if (upd_valid && (upd_idx == lookup_idx_s)) begin
      read_ctr_s = upd_next_s;
    end else begin
      read_ctr_s = table_r[lookup_idx_s];
    end
`endif
  end

  // Counter array: reset to strongly taken, single write port for updates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= 2'b11;
      end
    end else if (upd_valid) begin
      table_r[upd_idx] <= upd_next_s;
    end else begin
      table_r[upd_idx] <= table_r[upd_idx];
    end
  end

  // Global history: shifted only by resolved outcomes, never speculatively.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr_r <= {INDEX_W{1'b0}};
    end else if (upd_valid) begin
      ghr_r <= {ghr_r[INDEX_W-2:0], upd_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  // Prediction result register: one-cycle valid pulse, data holds when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_out_valid_r <= 1'b0;
      pred_taken_r     <= 1'b0;
      pred_ctr_r       <= 2'b00;
      pred_idx_r       <= {INDEX_W{1'b0}};
    end else if (pred_valid) begin
      pred_out_valid_r <= 1'b1;
      pred_taken_r     <= read_ctr_s[1];
      pred_ctr_r       <= read_ctr_s;
      pred_idx_r       <= lookup_idx_s;
    end else begin
      pred_out_valid_r <= 1'b0;
      pred_taken_r     <= pred_taken_r;
      pred_ctr_r       <= pred_ctr_r;
      pred_idx_r       <= pred_idx_r;
    end
  end

  assign pred_out_valid = pred_out_valid_r;
  assign pred_taken     = pred_taken_r;
  assign pred_ctr       = pred_ctr_r;
  assign pred_idx       = pred_idx_r;
  assign ghr_out        = ghr_r;

endmodule

// File: tb/tb_pht_predictor.sv
// -----------------------------------------------------------------------------
// tb_pht_predictor
//   Directed self-checking bench for pht_predictor (default parameters).
//   Build with +define+PHT_BYPASS_EN to check the forwarding variant.
// -----------------------------------------------------------------------------
module tb_pht_predictor;

  logic        clk;
  logic        resetn;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_out_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic [5:0]  ghr_out;

  int n_vec;
  int n_err;

  pht_predictor #(.INDEX_W(6), .PC_LSB(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .ghr_out        (ghr_out)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc,
                       input logic uv, input logic [5:0] ui, input logic ut);
    pred_valid = pv;
    pred_pc    = pc;
    upd_valid  = uv;
    upd_idx    = ui;
    upd_taken  = ut;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    resetn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    resetn = 1'b0;
    #12;
    n_vec++;
    if ({pred_out_valid, pred_taken, pred_ctr, pred_idx, ghr_out} !== 16'h0) begin
      $display("FAIL reset_outputs: got v=%0b t=%0b ctr=%0d idx=%0d ghr=%0d, want all 0",
               pred_out_valid, pred_taken, pred_ctr, pred_idx, ghr_out);
      n_err++;
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_predict_basic();
    drive(1'b1, 32'h0000_0010, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_out_valid !== 1'b1 || pred_idx !== 6'd4 || pred_ctr !== 2'b11 ||
        pred_taken !== 1'b1 || ghr_out !== 6'd0) begin
      $display("FAIL predict_basic: got v=%0b idx=%0d ctr=%0d t=%0b ghr=%0d, want v=1 idx=4 ctr=3 t=1 ghr=0",
               pred_out_valid, pred_idx, pred_ctr, pred_taken, ghr_out);
      n_err++;
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_out_valid !== 1'b0 || pred_idx !== 6'd4 || pred_ctr !== 2'b11 || pred_taken !== 1'b1) begin
      $display("FAIL predict_hold: got v=%0b idx=%0d ctr=%0d t=%0b, want v=0 idx=4 ctr=3 t=1",
               pred_out_valid, pred_idx, pred_ctr, pred_taken);
      n_err++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b10;
    exp_seq[1] = 2'b01;
    exp_seq[2] = 2'b00;
    exp_seq[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 6'd4, 1'b0);
      tick();
      drive(1'b1, 32'h0000_0010, 1'b0, 6'd0, 1'b0);
      tick();
      n_vec++;
      if (pred_ctr !== exp_seq[k] || pred_taken !== exp_seq[k][1] || pred_idx !== 6'd4) begin
        $display("FAIL saturate_step%0d: got ctr=%0d t=%0b idx=%0d, want ctr=%0d t=%0b idx=4",
                 k, pred_ctr, pred_taken, pred_idx, exp_seq[k], exp_seq[k][1]);
        n_err++;
      end
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    n_vec++;
    if (ghr_out !== 6'd0) begin
      $display("FAIL saturate_ghr: got %0d, want 0", ghr_out);
      n_err++;
    end
  endtask

  task automatic test_ghr();
    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b1);
    tick();
    n_vec++;
    if (ghr_out !== 6'b000101) begin
      $display("FAIL ghr_shift: got %b, want 000101", ghr_out);
      n_err++;
    end
    drive(1'b1, 32'h0000_0010, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_out_valid !== 1'b1 || pred_idx !== 6'd1 || pred_ctr !== 2'b11) begin
      $display("FAIL ghr_hash: got v=%0b idx=%0d ctr=%0d, want v=1 idx=1 ctr=3",
               pred_out_valid, pred_idx, pred_ctr);
      n_err++;
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
  endtask

  task automatic test_same_edge();
    logic [1:0] exp_ctr;
`ifdef PHT_BYPASS_EN
    exp_ctr = 2'b01;
`else
    exp_ctr = 2'b10;
`endif
    // Bring idx 4 to 10 (ghr stays 0 on a not-taken shift).
    drive(1'b0, 32'h0, 1'b1, 6'd4, 1'b0);
    tick();
    // Same-edge predict and update of idx 4.
    drive(1'b1, 32'h0000_0010, 1'b1, 6'd4, 1'b0);
    tick();
    n_vec++;
    if (pred_ctr !== exp_ctr || pred_taken !== exp_ctr[1] || pred_idx !== 6'd4) begin
      $display("FAIL same_edge_hit: got ctr=%0d t=%0b idx=%0d, want ctr=%0d t=%0b idx=4",
               pred_ctr, pred_taken, pred_idx, exp_ctr, exp_ctr[1]);
      n_err++;
    end
    drive(1'b1, 32'h0000_0010, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_ctr !== 2'b01 || pred_idx !== 6'd4) begin
      $display("FAIL same_edge_after: got ctr=%0d idx=%0d, want ctr=1 idx=4", pred_ctr, pred_idx);
      n_err++;
    end
    // Different indices at the same edge; hash must use the pre-shift GHR.
    drive(1'b1, 32'h0000_0000, 1'b1, 6'd4, 1'b1);
    tick();
    n_vec++;
    if (pred_idx !== 6'd0 || pred_ctr !== 2'b11 || ghr_out !== 6'd1) begin
      $display("FAIL same_edge_diff: got idx=%0d ctr=%0d ghr=%0d, want idx=0 ctr=3 ghr=1",
               pred_idx, pred_ctr, ghr_out);
      n_err++;
    end
    // pc 0x14 -> 5 ^ 1 = 4, counter stepped 01 -> 10.
    drive(1'b1, 32'h0000_0014, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_idx !== 6'd4 || pred_ctr !== 2'b10 || pred_taken !== 1'b1) begin
      $display("FAIL same_edge_diff_wr: got idx=%0d ctr=%0d t=%0b, want idx=4 ctr=2 t=1",
               pred_idx, pred_ctr, pred_taken);
      n_err++;
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(k * 4), 1'b0, 6'd0, 1'b0);
      tick();
      n_vec++;
      if (pred_out_valid !== 1'b1 || pred_idx !== 6'(k)) begin
        $display("FAIL back_to_back%0d: got v=%0b idx=%0d, want v=1 idx=%0d",
                 k, pred_out_valid, pred_idx, k);
        n_err++;
      end
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_out_valid !== 1'b0) begin
      $display("FAIL back_to_back_end: got v=%0b, want 0", pred_out_valid);
      n_err++;
    end
  endtask

  task automatic test_reset_midop();
    // Disturb state: several counters and the GHR.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1, 6'(k * 9), 1'(k % 2));
      tick();
      drive(1'b0, 32'h0, 1'b1, 6'(k * 9), 1'b0);
      tick();
    end
    drive(1'b1, 32'h0000_0020, 1'b0, 6'd0, 1'b0);
    tick();
    // pred_out_valid is high here; pull reset asynchronously mid-cycle.
    #2;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (pred_out_valid !== 1'b0 || ghr_out !== 6'd0) begin
      $display("FAIL reset_async: got v=%0b ghr=%0d, want v=0 ghr=0", pred_out_valid, ghr_out);
      n_err++;
    end
    tick();
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
    n_vec++;
    if (pred_out_valid !== 1'b0) begin
      $display("FAIL reset_no_pulse: got v=%0b, want 0", pred_out_valid);
      n_err++;
    end
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 6'd0, 1'b0);
      tick();
      n_vec++;
      if (pred_ctr !== 2'b11 || pred_idx !== 6'(i) || ghr_out !== 6'd0) begin
        $display("FAIL reset_table%0d: got ctr=%0d idx=%0d ghr=%0d, want ctr=3 idx=%0d ghr=0",
                 i, pred_ctr, pred_idx, ghr_out, i);
        n_err++;
      end
    end
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    test_reset();
    test_predict_basic();
    test_saturate();
    apply_reset();
    test_ghr();
    apply_reset();
    test_same_edge();
    apply_reset();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
